// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit CPU: the 4-bit opcode values that live in
// the upper nibble of every instruction byte, and the fetch unit state type.
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADN = 4'b0111;
   localparam logic [3:0] OP_INC = 4'b1000;
   localparam logic [3:0] OP_DEC = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1010;
   localparam logic [3:0] OP_CLR = 4'b1011;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // FETCH   : normal byte-per-cycle fetch
   // JMP_TGT : reading the target byte that follows a JMP opcode
   // HALT    : HLT seen, no further ROM reads until reset
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      JMP_TGT = 2'd1,
      HALT    = 2'd2
   } fetchState_e;

endpackage

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit: reads the program ROM one byte per cycle, resolves
// two-byte JMP internally, stops on HLT and hands every other byte to the
// decoder over a valid/ready handshake. Execute may redirect the PC.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   rom_addr/read/ena : ROM request (combinational from state, pc, slot_free)
//   rom_data          : ROM byte, returned in the same cycle as the request
//   instr, instr_pc   : fetched byte and the address it came from
//   instr_valid       : instr/instr_pc hold a byte for the decoder
//   instr_ready       : decoder accepts the byte this cycle
//   redirect_valid    : execute-stage PC override (ignored once halted)
//   redirect_addr     : new PC on redirect
//   halted            : HLT fetched, fetch stopped
// ---------------------------------------------------------------------------
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_read,
   output logic              rom_ena,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              halted
);

   fetchState_e       state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] instr_q;
   logic [ADDR_W-1:0] instrPc_q;
   logic              instrValid_q;
   logic              halted_q;

   logic              slotFree;
   logic [ADDR_W-1:0] pcInc_d;
   logic [3:0]        opcode;

   // The output slot can take a new byte when it is empty or being drained
   // this very cycle. The PC increment wraps naturally at the address width.
   assign slotFree = !instrValid_q || instr_ready;
   assign pcInc_d  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign opcode   = rom_data[DATA_W-1 -: 4];

   // ROM request: the JMP target read never needs the output slot, a normal
   // fetch only goes out when the fetched byte has somewhere to land. The
   // strobe is held low while reset is asserted.
   always_comb begin
      rom_read = 1'b0;
      if (!rst) begin
         case (state_q)
            FETCH:   rom_read = slotFree;
            JMP_TGT: rom_read = 1'b1;
            default: rom_read = 1'b0;
         endcase
      end
   end

   assign rom_ena  = rom_read;
   assign rom_addr = pc_q;

   // Fetch FSM together with the PC and output registers. Redirect wins over
   // everything except HALT and throws away both the pending output byte and
   // whatever the ROM returned this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         instr_q      <= '0;
         instrPc_q    <= '0;
         instrValid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (redirect_valid) begin
                  pc_q         <= redirect_addr;
                  instrValid_q <= 1'b0;
               end else if (slotFree) begin
                  pc_q <= pcInc_d;
                  if (opcode == OP_JMP) begin
                     state_q      <= JMP_TGT;
                     instrValid_q <= 1'b0;
                  end else begin
                     instr_q      <= rom_data;
                     instrPc_q    <= pc_q;
                     instrValid_q <= 1'b1;
                     if (opcode == OP_HLT) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                     end
                  end
               end
            end
            JMP_TGT: begin
               state_q <= FETCH;
               if (redirect_valid) begin
                  pc_q         <= redirect_addr;
                  instrValid_q <= 1'b0;
               end else begin
                  pc_q <= rom_data[ADDR_W-1:0];
                  if (instr_ready) begin
                     instrValid_q <= 1'b0;
                  end
               end
            end
            HALT: begin
               if (instr_ready) begin
                  instrValid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instrPc_q;
   assign instr_valid = instrValid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A ROM model drives rom_data from
// rom_addr. An instruction-level walker over the ROM image produces the list
// of (byte, pc) pairs the decoder should receive; a monitor pops and compares
// on every accepted handshake.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rom_addr;
   logic       rom_read;
   logic       rom_ena;
   logic [7:0] rom_data;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       redirect_valid;
   logic [7:0] redirect_addr;
   logic       halted;

   logic [7:0]  rom [0:255];
   logic [15:0] expQ [$];
   int          checks = 0;
   int          errors = 0;

   instr_fetch #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_read       (rom_read),
      .rom_ena        (rom_ena),
      .rom_data       (rom_data),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halted         (halted)
   );

   // Free-running clock, asynchronous-read ROM image
   always #5 clk = ~clk;
   assign rom_data = rom[rom_addr];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted byte must be the next one the model predicted
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedByte", {instr, instr_pc}, 16'hxxxx);
         end else begin
            logic [15:0] e;
            e = expQ.pop_front();
            checkOutput("instrByte", instr, e[15:8]);
            checkOutput("instrPc", instr_pc, e[7:0]);
         end
      end
   end

   // Instruction-level reference: follow the program from start, taking JMP
   // targets from the following byte, queueing every other byte until HLT.
   function automatic bit walk(input logic [7:0] start, input int maxEmit);
      logic [7:0] pc;
      logic [7:0] nx;
      logic [7:0] b;
      int         emits;
      pc = start;
      emits = 0;
      for (int steps = 0; steps < 300 && emits < maxEmit; steps++) begin
         b = rom[pc];
         if (b[7:4] == OP_JMP) begin
            nx = pc + 8'd1;
            pc = rom[nx];
         end else begin
            expQ.push_back({b, pc});
            emits++;
            if (b[7:4] == OP_HLT) return 1'b1;
            pc = pc + 8'd1;
         end
      end
      return 1'b0;
   endfunction

   task automatic clearRom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   task automatic resetDut();
      rst = 1'b1;
      redirect_valid = 1'b0;
      instr_ready = 1'b0;
      #1;
      checkOutput("rstRomRead", {rom_read, rom_ena}, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      checkOutput("rstAddr", rom_addr, 8'h00);
      checkOutput("rstValid", instr_valid, 1'b0);
      checkOutput("rstHalted", halted, 1'b0);
   endtask

   // Run the DUT until the scoreboard drains. mode 0: ready high,
   // 1: random ready, 2: hold ready low 5 cycles while pc 2 is presented,
   // 3: redirect to 8'h40 while pc 5 is presented.
   task automatic applyStimulus(input int mode, input int budget, output int cyc);
      int holdCnt;
      bit holdNow;
      bit redirDone;
      bit redirPend;
      holdCnt = 0;
      redirDone = 1'b0;
      redirPend = 1'b0;
      cyc = 0;
      instr_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      while (cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
         holdNow = 1'b0;
         if (redirPend) begin
            checkOutput("redirFlush", instr_valid, 1'b0);
            redirect_valid = 1'b0;
            redirPend = 1'b0;
         end
         case (mode)
            1: instr_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (instr_valid && instr_pc == 8'h02 && holdCnt < 5) begin
                  instr_ready = 1'b0;
                  holdCnt++;
                  holdNow = 1'b1;
               end else begin
                  instr_ready = 1'b1;
               end
            end
            3: begin
               if (instr_valid && instr_pc == 8'h05 && !redirDone) begin
                  instr_ready = 1'b0;
                  redirect_valid = 1'b1;
                  redirect_addr = 8'h40;
                  redirDone = 1'b1;
                  redirPend = 1'b1;
               end else begin
                  instr_ready = 1'b1;
               end
            end
            default: instr_ready = 1'b1;
         endcase
         @(negedge clk);
         #1;
         if (holdNow) begin
            checkOutput("holdInstr", instr, 8'h82);
            checkOutput("holdPc", instr_pc, 8'h02);
            checkOutput("holdRomRead", rom_read, 1'b0);
            checkOutput("holdAddr", rom_addr, 8'h03);
         end
         if (expQ.size() == 0) break;
      end
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      if (expQ.size() != 0) checkOutput("drainTimeout", expQ.size(), 0);
      if (mode == 2) checkOutput("holdCycles", holdCnt, 5);
      if (mode == 3) checkOutput("redirIssued", redirDone, 1'b1);
   endtask

   initial begin
      int  cyc;
      bit  expHalt;
      rst = 1'b1;
      instr_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr = 8'h00;
      clearRom();
      @(negedge clk);
      resetDut();

      // Straight-line program ending in HLT, one byte per cycle
      clearRom();
      rom[0] = 8'h00; rom[1] = 8'h81; rom[2] = 8'h81; rom[3] = 8'hF0;
      expHalt = walk(8'h00, 50);
      applyStimulus(0, 100, cyc);
      checkOutput("straightCycles", cyc, 4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("haltFlag", halted, 1'b1);
         checkOutput("haltRomRead", rom_read, 1'b0);
      end
      resetDut();

      // JMP at 7 to 15: two silent cycles, bytes 7/8 never emitted
      clearRom();
      rom[7] = 8'hA3; rom[8] = 8'h0F; rom[15] = 8'h81; rom[16] = 8'hB0; rom[17] = 8'hF0;
      expHalt = walk(8'h00, 50);
      applyStimulus(0, 100, cyc);
      checkOutput("jmpCycles", cyc, 12);
      resetDut();

      // Backpressure while pc 2 is presented
      clearRom();
      rom[0] = 8'h00; rom[1] = 8'h81; rom[2] = 8'h82; rom[3] = 8'h83; rom[4] = 8'hF0;
      expHalt = walk(8'h00, 50);
      applyStimulus(2, 100, cyc);
      checkOutput("holdTotalCycles", cyc, 10);
      resetDut();

      // Redirect flushes the byte from pc 5
      clearRom();
      rom[5] = 8'h81; rom[8'h40] = 8'h82; rom[8'h41] = 8'hF0;
      expHalt = walk(8'h00, 5);
      expHalt = walk(8'h40, 50);
      applyStimulus(3, 100, cyc);
      checkOutput("redirHalted", halted, 1'b1);
      resetDut();

      // Wrap: FE, JMP at FF takes its target from 00; redirect while halted
      clearRom();
      rom[8'h00] = 8'hA0; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'h81;
      rom[8'hFF] = 8'hA0; rom[8'hA0] = 8'hF0;
      expHalt = walk(8'h00, 50);
      applyStimulus(0, 100, cyc);
      checkOutput("wrapHalted", halted, 1'b1);
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr = 8'h10;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("haltRedirFlag", halted, 1'b1);
         checkOutput("haltRedirRead", rom_read, 1'b0);
         checkOutput("haltRedirAddr", rom_addr, 8'hA1);
      end
      redirect_valid = 1'b0;
      instr_ready = 1'b0;
      resetDut();

      // Reset while reading a JMP target
      clearRom();
      rom[0] = 8'h00; rom[1] = 8'hA0; rom[2] = 8'h10; rom[8'h10] = 8'hF0;
      expQ.push_back({8'h00, 8'h00});
      expHalt = walk(8'h00, 50);
      instr_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("jmpTgtAddr", rom_addr, 8'h02);
      checkOutput("jmpTgtRead", rom_read, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midJmpAddr", rom_addr, 8'h00);
      checkOutput("midJmpValid", instr_valid, 1'b0);
      checkOutput("midJmpHalted", halted, 1'b0);
      applyStimulus(0, 100, cyc);
      checkOutput("midJmpEndHalt", halted, 1'b1);
      resetDut();

      // Random programs with random decoder backpressure
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
         expHalt = walk(8'h00, 30);
         applyStimulus(1, 600, cyc);
         if (expHalt) checkOutput("randHalted", halted, 1'b1);
         resetDut();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound in case the bench itself stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
